simp_timer: RTL and testbench
=============================

# simp_timer

Memory-mapped 64-bit machine timer acting as a simp-bus slave, placed directly downstream of the AXI-Lite-to-simp bridge. It answers simp reads/writes to a small register file (control, prescaler, mtime, mtimecmp, status) and drives a level timer interrupt to the core. Address decode of the peripheral region happens upstream; this block decodes only the low address bits.

## Interface

- `PRESCALE_WIDTH`, default 16: width of the prescaler register and counter.
- `MTIMECMP_RST`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.

- `clk`  in  1  single clock; all state on posedge.
- `rst`  in  1  reset, asynchronous, active-low (block held in reset while 0).
- `simp_addr`  in  32  byte address; only [4:2] decoded, [1:0] and [31:5] ignored.
- `simp_data_in`  in  32  write data.
- `simp_wr`  in  1  write request.
- `simp_rd`  in  1  read request.
- `simp_valid`  in  1  request valid; held with addr/wr/rd/be/data until done.
- `simp_be`  in  4  byte enables for writes; ignored on reads.
- `simp_data_out`  out  32  read data, valid in the done cycle.
- `simp_done`  out  1  one-cycle completion pulse; handshake = valid && done.
- `timer_irq_o`  out  1  level interrupt to core.

## Operation

- Register map (word offset via addr[4:2]):
  - 0 CTRL: bit0 EN, bit1 IRQ_EN; other bits read 0.
  - 1 PRESCALE: [PRESCALE_WIDTH-1:0]; upper bits read 0.
  - 2 MTIME_LO; 3 MTIME_HI; 4 MTIMECMP_LO; 5 MTIMECMP_HI.
  - 6 STATUS (read-only): bit0 = (mtime >= mtimecmp), unsigned 64-bit.
  - 7 unmapped: reads 0, writes ignored.
- Writes: each byte lane updated only where simp_be bit set; be=0 is a legal no-op write that still completes.
- Reads: MTIME_LO returns live mtime[31:0] and captures live mtime[63:32] into hi_shadow in the same cycle; MTIME_HI returns hi_shadow (not live). Other reads return live values.
- rd && wr both high: no register effect, data_out = 0, done still asserted. valid with neither rd nor wr: same.
- Slave FSM:
  - IDLE: if simp_valid, perform access (write commit / read data into output register), go to DONE.
  - DONE: simp_done=1, simp_data_out holds read data (0 for writes); go to GAP.
  - GAP: done=0, request lines ignored (master is dropping valid); go to IDLE.
- Timer: when EN=1, prescale counter counts 0..PRESCALE; in the cycle it equals PRESCALE it returns to 0 and mtime increments by 1 (64-bit wrap to 0). PRESCALE=0 means increment every cycle. EN=0 freezes both counter and mtime.
- Write to PRESCALE (any lane) resets prescale counter to 0.
- Write to MTIME_LO/HI in a tick cycle: written bytes take write value, unwritten bytes keep pre-tick value, tick is lost.
- timer_irq_o registered: IRQ_EN && (mtime >= mtimecmp), from the current-cycle values.

## Timing

- Reset values: simp_done 0, simp_data_out 0, timer_irq_o 0, CTRL 0, PRESCALE 0, prescale counter 0, mtime 0, hi_shadow 0, mtimecmp MTIMECMP_RST, FSM IDLE.
- Reset assertion mid-transaction: FSM returns to IDLE immediately, no done issued; the master reissues.
- Request sampled in IDLE at cycle N -> simp_done high exactly in cycle N+1, low in N+2; earliest next acceptance N+3.
- Write effects visible to a read accepted at the next IDLE and to mtime/irq logic from cycle N+1.
- timer_irq_o: rises/falls one cycle after the compare condition or IRQ_EN changes.
- simp_data_out holds its last value outside done cycles; verification checks it only at handshake.

## Test plan

- Reset release, read all 8 offsets -> CTRL 0, PRESCALE 0, MTIME 0/0, MTIMECMP FFFFFFFF/FFFFFFFF, STATUS 0, offset 7 reads 0; each done exactly one cycle after valid, one cycle wide.
- Write PRESCALE=3, CTRL=1; wait 40 cycles -> mtime advanced by 10 (±1 for the access window), one increment per 4 cycles.
- Write MTIME_LO=FFFFFFFE, MTIME_HI=0, PRESCALE=0, EN=1; after carry read LO then HI -> HI returns the value shadowed at the LO read (1 if LO read after wrap), never a torn value.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=3 with PRESCALE=0 from mtime 0 -> timer_irq_o rises one cycle after mtime reaches 20; clearing IRQ_EN drops it one cycle later.
- Byte-enable write 0xAABBCCDD with be=4'b0101 to MTIMECMP_LO (reset FFFFFFFF) -> reads FFBBFFDD; be=0 write changes nothing but completes.
- rd&&wr both high to CTRL with data 3 -> done asserted, data_out 0, CTRL unchanged; assert rst low during DONE -> done drops, outputs at reset values.

Source files
------------

// File: rtl/simp_timer.sv
// 64-bit machine timer on the simp bus: CTRL/PRESCALE/MTIME/MTIMECMP/STATUS register file,
// prescaled mtime counter and a registered level interrupt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for simp_valid; access is performed on acceptance
// ST_DONE | simp_done high, simp_data_out holds the access result
// ST_GAP  | request lines ignored while the master drops valid
module simp_timer #(
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [63:0] MTIMECMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] simp_addr,
  input  logic [31:0] simp_data_in,
  input  logic        simp_wr,
  input  logic        simp_rd,
  input  logic        simp_valid,
  input  logic [3:0]  simp_be,
  output logic [31:0] simp_data_out,
  output logic        simp_done,
  output logic        timer_irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_PRESCALE = 3'd1;
  localparam logic [2:0] OFS_MTIME_LO = 3'd2;
  localparam logic [2:0] OFS_MTIME_HI = 3'd3;
  localparam logic [2:0] OFS_CMP_LO   = 3'd4;
  localparam logic [2:0] OFS_CMP_HI   = 3'd5;
  localparam logic [2:0] OFS_STATUS   = 3'd6;

  state_t                    state, state_nxt;
  logic                      access;
  logic                      do_wr, do_rd;
  logic                      wr_any;
  logic [2:0]                offset;
  logic [31:0]               rdata;

  logic                      ctrl_en, ctrl_irq_en;
  logic [PRESCALE_WIDTH-1:0] prescale, presc_cnt, presc_cnt_nxt;
  logic [63:0]               mtime, mtime_nxt;
  logic [63:0]               mtimecmp;
  logic [31:0]               hi_shadow;
  logic                      tick;
  logic                      cmp_hit;
  logic [31:0]               prescale_ext;

  logic                      unused_addr;
  assign unused_addr = ^{simp_addr[31:5], simp_addr[1:0]};

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (simp_valid) begin
          access    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign offset       = simp_addr[4:2];
  assign do_wr        = access && simp_wr && !simp_rd;
  assign do_rd        = access && simp_rd && !simp_wr;
  assign wr_any       = do_wr && (simp_be != 4'b0000);
  assign simp_done    = (state == ST_DONE);
  assign prescale_ext = 32'(prescale);
  assign cmp_hit      = (mtime >= mtimecmp);
  assign tick         = ctrl_en && (presc_cnt == prescale);

  always_comb begin
    rdata = '0;
    case (offset)
      OFS_CTRL:     rdata = {30'd0, ctrl_irq_en, ctrl_en};
      OFS_PRESCALE: rdata = prescale_ext;
      OFS_MTIME_LO: rdata = mtime[31:0];
      OFS_MTIME_HI: rdata = hi_shadow;
      OFS_CMP_LO:   rdata = mtimecmp[31:0];
      OFS_CMP_HI:   rdata = mtimecmp[63:32];
      OFS_STATUS:   rdata = {31'd0, cmp_hit};
      default:      rdata = '0;
    endcase
  end

  // A bus write to either mtime half replaces the tick for that cycle.
  always_comb begin
    mtime_nxt     = tick ? mtime + 64'd1 : mtime;
    presc_cnt_nxt = presc_cnt;
    if (ctrl_en) presc_cnt_nxt = tick ? '0 : presc_cnt + PRESCALE_WIDTH'(1);
    if (wr_any && offset == OFS_PRESCALE) presc_cnt_nxt = '0;
    if (wr_any && offset == OFS_MTIME_LO)
      mtime_nxt = {mtime[63:32], merge_be(mtime[31:0], simp_data_in, simp_be)};
    if (wr_any && offset == OFS_MTIME_HI)
      mtime_nxt = {merge_be(mtime[63:32], simp_data_in, simp_be), mtime[31:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime     <= '0;
      presc_cnt <= '0;
    end else begin
      mtime     <= mtime_nxt;
      presc_cnt <= presc_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      prescale    <= '0;
      mtimecmp    <= MTIMECMP_RST;
    end else if (wr_any) begin
      case (offset)
        OFS_CTRL: begin
          if (simp_be[0]) begin
            ctrl_en     <= simp_data_in[0];
            ctrl_irq_en <= simp_data_in[1];
          end
        end
        OFS_PRESCALE: prescale <= PRESCALE_WIDTH'(merge_be(prescale_ext, simp_data_in, simp_be));
        OFS_CMP_LO:   mtimecmp[31:0]  <= merge_be(mtimecmp[31:0], simp_data_in, simp_be);
        OFS_CMP_HI:   mtimecmp[63:32] <= merge_be(mtimecmp[63:32], simp_data_in, simp_be);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      simp_data_out <= '0;
      hi_shadow     <= '0;
      timer_irq_o   <= 1'b0;
    end else begin
      if (access) simp_data_out <= do_rd ? rdata : 32'd0;
      if (do_rd && offset == OFS_MTIME_LO) hi_shadow <= mtime[63:32];
      timer_irq_o <= ctrl_irq_en && cmp_hit;
    end
  end

endmodule

// File: tb/tb_simp_timer.sv
// Directed bench for simp_timer: register access, prescaled counting, hi-shadow reads,
// interrupt timing, byte enables, illegal requests and reset during a transaction.
module tb_simp_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] simp_addr = '0;
  logic [31:0] simp_data_in = '0;
  logic        simp_wr = 1'b0;
  logic        simp_rd = 1'b0;
  logic        simp_valid = 1'b0;
  logic [3:0]  simp_be = '0;
  logic [31:0] simp_data_out;
  logic        simp_done;
  logic        timer_irq_o;

  int n_chk = 0;
  int n_err = 0;

  simp_timer dut (
    .clk           (clk),
    .rst           (rst),
    .simp_addr     (simp_addr),
    .simp_data_in  (simp_data_in),
    .simp_wr       (simp_wr),
    .simp_rd       (simp_rd),
    .simp_valid    (simp_valid),
    .simp_be       (simp_be),
    .simp_data_out (simp_data_out),
    .simp_done     (simp_done),
    .timer_irq_o   (timer_irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request; done must be high the cycle after acceptance and low the next.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic rd,
                      input logic [3:0] be, input logic [31:0] data,
                      output logic [31:0] rdata);
    @(negedge clk);
    simp_addr    = addr;
    simp_wr      = wr;
    simp_rd      = rd;
    simp_be      = be;
    simp_data_in = data;
    simp_valid   = 1'b1;
    @(posedge clk);
    #1;
    check("done_hi", simp_done, 1);
    rdata = simp_data_out;
    @(posedge clk);
    #1;
    simp_valid = 1'b0;
    simp_wr    = 1'b0;
    simp_rd    = 1'b0;
    check("done_lo", simp_done, 0);
    @(posedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] ofs, input logic [31:0] data,
                        input logic [3:0] be = 4'hF);
    logic [31:0] dummy;
    xfer({27'd0, ofs, 2'b00}, 1'b1, 1'b0, be, data, dummy);
  endtask

  task automatic rd_reg(input logic [2:0] ofs, output logic [31:0] data);
    xfer({27'd0, ofs, 2'b00}, 1'b0, 1'b1, 4'h0, 32'd0, data);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] ofs, input logic [31:0] exp);
    logic [31:0] v;
    rd_reg(ofs, v);
    check(tag, v, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_rst [8];
    logic [31:0] v, a, b;
    exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", simp_done, 0);
    check("rst_dout", simp_data_out, 0);
    check("rst_irq", timer_irq_o, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) rd_chk("rst_reg", 3'(i), exp_rst[i]);

    // address bits outside [4:2] are ignored; offset 7 and STATUS discard writes
    wr_reg(3'd1, 32'h0000_0007);
    xfer(32'h1234_5687, 1'b0, 1'b1, 4'h0, 32'd0, v);
    check("addr_alias", v, 32'h0000_0007);
    wr_reg(3'd7, 32'hDEAD_BEEF);
    rd_chk("unmapped", 3'd7, 32'h0);
    wr_reg(3'd6, 32'hFFFF_FFFF);
    rd_chk("status_ro", 3'd6, 32'h0);

    // prescaled counting: one increment per 4 cycles
    wr_reg(3'd1, 32'h0000_0003);
    wr_reg(3'd0, 32'h0000_0001);
    repeat (40) @(posedge clk);
    rd_reg(3'd2, a);
    check("presc_rate", (a >= 9 && a <= 11), 1);
    repeat (40) @(posedge clk);
    rd_reg(3'd2, b);
    check("presc_rate2", ((b - a) >= 9 && (b - a) <= 11), 1);
    wr_reg(3'd0, 32'h0);
    rd_reg(3'd2, a);
    repeat (20) @(posedge clk);
    rd_reg(3'd2, b);
    check("frozen", b, a);

    // carry into the high word, HI read returns the shadow taken at the LO read
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd2, 32'hFFFF_FFFE);
    wr_reg(3'd3, 32'h0);
    wr_reg(3'd0, 32'h1);
    repeat (10) @(posedge clk);
    rd_chk("carry_lo", 3'd2, 32'h0000_000A);
    rd_chk("carry_hi", 3'd3, 32'h0000_0001);
    wr_reg(3'd0, 32'h0);
    wr_reg(3'd2, 32'hFFFF_FFF8);
    wr_reg(3'd3, 32'h0000_0005);
    wr_reg(3'd0, 32'h1);
    rd_chk("shadow_lo", 3'd2, 32'hFFFF_FFFA);
    repeat (20) @(posedge clk);
    rd_chk("shadow_hold", 3'd3, 32'h0000_0005);
    rd_reg(3'd2, v);
    rd_chk("shadow_new", 3'd3, 32'h0000_0006);

    // interrupt timing against mtimecmp = 20
    wr_reg(3'd0, 32'h0);
    wr_reg(3'd3, 32'h0);
    wr_reg(3'd2, 32'h0);
    wr_reg(3'd5, 32'h0);
    wr_reg(3'd4, 32'd20);
    wr_reg(3'd0, 32'h3);
    repeat (18) @(posedge clk);
    #1;
    check("irq_before", timer_irq_o, 0);
    @(posedge clk);
    #1;
    check("irq_rise", timer_irq_o, 1);
    rd_chk("status_hit", 3'd6, 32'h1);
    @(negedge clk);
    simp_addr = 32'h0; simp_data_in = 32'h1; simp_be = 4'hF;
    simp_wr = 1'b1; simp_rd = 1'b0; simp_valid = 1'b1;
    @(posedge clk);
    #1;
    check("irq_hold", timer_irq_o, 1);
    @(posedge clk);
    #1;
    simp_valid = 1'b0; simp_wr = 1'b0;
    check("irq_fall", timer_irq_o, 0);
    @(posedge clk);

    // byte enables
    wr_reg(3'd4, 32'hFFFF_FFFF);
    wr_reg(3'd4, 32'hAABB_CCDD, 4'b0101);
    rd_chk("be_0101", 3'd4, 32'hFFBB_FFDD);
    wr_reg(3'd4, 32'h1234_5678, 4'b0000);
    rd_chk("be_none", 3'd4, 32'hFFBB_FFDD);

    // rd && wr together, and valid with neither
    wr_reg(3'd0, 32'h2);
    rd_chk("ctrl_2", 3'd0, 32'h2);
    xfer(32'h0, 1'b1, 1'b1, 4'hF, 32'h3, v);
    check("rdwr_dout", v, 32'h0);
    rd_chk("rdwr_ctrl", 3'd0, 32'h2);
    xfer(32'h0, 1'b0, 1'b0, 4'hF, 32'h3, v);
    check("none_dout", v, 32'h0);
    rd_chk("none_ctrl", 3'd0, 32'h2);

    // reset asserted during DONE
    @(negedge clk);
    simp_addr = 32'h0; simp_rd = 1'b1; simp_wr = 1'b0; simp_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mid_done", simp_done, 1);
    check("mid_dout", simp_data_out, 32'h2);
    rst = 1'b0;
    #1;
    check("mid_rst_done", simp_done, 0);
    check("mid_rst_dout", simp_data_out, 0);
    check("mid_rst_irq", timer_irq_o, 0);
    @(negedge clk);
    simp_valid = 1'b0; simp_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd_chk("post_ctrl", 3'd0, 32'h0);
    rd_chk("post_cmp_lo", 3'd4, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
